// File: rtl/serial_config_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_config_rx
//  Purpose  : Receives a 104-bit serial configuration frame on sck/sda and
//             commits it into thirteen 8-bit registers when scapt rises.
//             All serial inputs are asynchronous and are synchronised.
//  Revision : 1.0  initial release
// ============================================================================
module serial_config_rx #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  RESET_VAL   = 8'h00
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       sck,
   input  logic       sda,
   input  logic       scapt,
   input  logic       reset,
   output logic [7:0] myReg1,
   output logic [7:0] myReg2,
   output logic [7:0] myReg3,
   output logic [7:0] myReg4,
   output logic [7:0] myReg5,
   output logic [7:0] myReg6,
   output logic [7:0] myReg7,
   output logic [7:0] myReg8,
   output logic [7:0] myReg9,
   output logic [7:0] myReg10,
   output logic [7:0] myReg11,
   output logic [7:0] myReg12,
   output logic [7:0] myReg13,
   output logic       cfg_valid,
   output logic       frame_err,
   output logic [6:0] bit_cnt
);

   localparam int         FRAME_BITS = 104;
   localparam int         NUM_REGS   = 13;
   localparam logic [6:0] CNT_MAX    = 7'd127;
   localparam logic [6:0] CNT_FULL   = 7'd104;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // Channel order inside the synchroniser bank: 0=sck 1=sda 2=scapt 3=reset
   logic [3:0]             raw_in;
   logic [SYNC_STAGES-1:0] sync_chain [4];
   logic [3:0]             sync_lvl;
   logic [3:0]             edge_q;

   logic                   sck_rise;
   logic                   scapt_rise;
   logic                   sda_s;
   logic                   cfg_rst;

   logic [FRAME_BITS-1:0]  shift_q;
   logic [FRAME_BITS-1:0]  shift_next;
   logic [6:0]             cnt_next;
   state_t                 state;
   state_t                 state_next;
   logic [7:0]             cfg_reg [NUM_REGS];

   assign raw_in = {reset, scapt, sda, sck};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         sync_lvl[i] = sync_chain[i][SYNC_STAGES-1];
      end
   end

   // Synchroniser chains plus one edge-detect flop per serial input
   always_ff @(posedge sysclk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            sync_chain[i] <= '0;
            edge_q[i]     <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], raw_in[i]};
            edge_q[i]     <= sync_lvl[i];
         end
      end
   end

   // sda and the config reset are taken after the edge flop; sda was set up
   // long before sck rises so the extra cycle costs nothing.
   assign sck_rise   = sync_lvl[0] & ~edge_q[0];
   assign scapt_rise = sync_lvl[2] & ~edge_q[2];
   assign sda_s      = edge_q[1];
   assign cfg_rst    = edge_q[3];

   function automatic state_t state_of(input logic [6:0] c);
      if (c == 7'd0)          return ST_IDLE;
      else if (c < CNT_FULL)  return ST_SHIFT;
      else if (c == CNT_FULL) return ST_FULL;
      else                    return ST_OVER;
   endfunction

   // Post-shift view, so a capture in the same cycle sees the new count
   always_comb begin
      shift_next = shift_q;
      cnt_next   = bit_cnt;
      state_next = state;
      if (sck_rise) begin
         shift_next = {shift_q[FRAME_BITS-2:0], sda_s};
         cnt_next   = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 7'd1;
         state_next = state_of(cnt_next);
      end
   end

   // Frame state machine: shifting, capture/commit and configuration reset
   always_ff @(posedge sysclk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REGS; k++) cfg_reg[k] <= RESET_VAL;
         shift_q   <= '0;
         bit_cnt   <= '0;
         cfg_valid <= 1'b0;
         frame_err <= 1'b0;
         state     <= ST_IDLE;
      end else if (cfg_rst) begin
         for (int k = 0; k < NUM_REGS; k++) cfg_reg[k] <= RESET_VAL;
         shift_q   <= '0;
         bit_cnt   <= '0;
         cfg_valid <= 1'b0;
         frame_err <= 1'b0;
         state     <= ST_IDLE;
      end else begin
         cfg_valid <= 1'b0;
         shift_q   <= shift_next;
         if (scapt_rise) begin
            if (state_next == ST_FULL) begin
               for (int k = 0; k < NUM_REGS; k++) begin
                  cfg_reg[k] <= shift_next[FRAME_BITS-1-8*k -: 8];
               end
               cfg_valid <= 1'b1;
               frame_err <= 1'b0;
            end else begin
               frame_err <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= ST_IDLE;
         end else begin
            bit_cnt <= cnt_next;
            state   <= state_next;
         end
      end
   end

   assign myReg1  = cfg_reg[0];
   assign myReg2  = cfg_reg[1];
   assign myReg3  = cfg_reg[2];
   assign myReg4  = cfg_reg[3];
   assign myReg5  = cfg_reg[4];
   assign myReg6  = cfg_reg[5];
   assign myReg7  = cfg_reg[6];
   assign myReg8  = cfg_reg[7];
   assign myReg9  = cfg_reg[8];
   assign myReg10 = cfg_reg[9];
   assign myReg11 = cfg_reg[10];
   assign myReg12 = cfg_reg[11];
   assign myReg13 = cfg_reg[12];

endmodule
`default_nettype wire

// File: tb/tb_serial_config_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_config_rx
//  Purpose  : Self-checking bench for serial_config_rx with a frame-level
//             reference model (bit queue -> register bytes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_config_rx;

   localparam logic [7:0] RV = 8'h3C;

   logic       sysclk = 1'b0;
   logic       rst    = 1'b0;
   logic       sck    = 1'b0;
   logic       sda    = 1'b0;
   logic       scapt  = 1'b0;
   logic       creset = 1'b0;
   logic [7:0] r [13];
   logic       cfg_valid;
   logic       frame_err;
   logic [6:0] bit_cnt;

   serial_config_rx #(.SYNC_STAGES(2), .RESET_VAL(RV)) dut (
      .sysclk(sysclk), .rst(rst), .sck(sck), .sda(sda), .scapt(scapt), .reset(creset),
      .myReg1(r[0]), .myReg2(r[1]), .myReg3(r[2]), .myReg4(r[3]), .myReg5(r[4]),
      .myReg6(r[5]), .myReg7(r[6]), .myReg8(r[7]), .myReg9(r[8]), .myReg10(r[9]),
      .myReg11(r[10]), .myReg12(r[11]), .myReg13(r[12]),
      .cfg_valid(cfg_valid), .frame_err(frame_err), .bit_cnt(bit_cnt)
   );

   always #5 sysclk = ~sysclk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: bits since last capture, committed bytes, sticky error
   bit         q [$];
   logic [7:0] mreg [13];
   bit         mferr;

   typedef struct {
      int           nbits;
      logic [103:0] data;
      int           exp_cnt;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_cnt();
      return (q.size() > 127) ? 127 : q.size();
   endfunction

   task automatic model_capture(output bit ok);
      ok = (q.size() == 104);
      if (ok) begin
         for (int k = 0; k < 13; k++)
            for (int b = 0; b < 8; b++) mreg[k][7-b] = q[8*k+b];
         mferr = 1'b0;
      end else begin
         mferr = 1'b1;
      end
      q.delete();
   endtask

   task automatic model_clear();
      for (int k = 0; k < 13; k++) mreg[k] = RV;
      mferr = 1'b0;
      q.delete();
   endtask

   task automatic check_regs(input string tag, input logic [7:0] exp [13]);
      for (int k = 0; k < 13; k++) chk($sformatf("%s myReg%0d", tag, k + 1), {24'h0, r[k]}, {24'h0, exp[k]});
   endtask

   task automatic shift_bit(input bit b);
      @(negedge sysclk);
      sda = b;
      repeat (4) @(negedge sysclk);
      sck = 1'b1;
      q.push_back(b);
      repeat (4) @(negedge sysclk);
      sck = 1'b0;
   endtask

   task automatic shift_frame(input logic [103:0] d, input int n);
      for (int i = 0; i < n; i++) shift_bit(d[103 - (i % 104)]);
   endtask

   // Capture strobe; with_sck raises the final sck in the same cycle as scapt
   task automatic capture(input string tag, input bit with_sck, input bit last_b);
      logic [7:0] old [13];
      bit ok;
      @(negedge sysclk);
      if (with_sck) begin
         sda = last_b;
         repeat (4) @(negedge sysclk);
         sck = 1'b1;
         q.push_back(last_b);
      end
      old = mreg;
      model_capture(ok);
      scapt = 1'b1;
      @(posedge sysclk); #1;
      chk({tag, " valid e1"}, {31'h0, cfg_valid}, 32'h0);
      @(posedge sysclk); #1;
      chk({tag, " valid e2"}, {31'h0, cfg_valid}, 32'h0);
      check_regs({tag, " pre"}, old);
      @(posedge sysclk); #1;
      chk({tag, " valid e3"}, {31'h0, cfg_valid}, {31'h0, ok});
      check_regs({tag, " post"}, mreg);
      chk({tag, " frame_err"}, {31'h0, frame_err}, {31'h0, mferr});
      chk({tag, " bit_cnt"}, {25'h0, bit_cnt}, 32'h0);
      @(posedge sysclk); #1;
      chk({tag, " valid e4"}, {31'h0, cfg_valid}, 32'h0);
      repeat (2) @(negedge sysclk);
      scapt = 1'b0;
      sck   = 1'b0;
      repeat (4) @(negedge sysclk);
   endtask

   initial begin
      logic [103:0] f0;
      logic [103:0] d;
      int n;
      bit sim;

      f0 = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd16};
      tbl[0] = '{104, f0, 104};
      tbl[1] = '{103, 104'h0123_4567_89AB_CDEF_FEDC_BA98_76, 103};
      tbl[2] = '{104, {13{8'h5A}}, 104};
      tbl[3] = '{130, {13{8'hC3}}, 127};
      tbl[4] = '{0, {13{8'hFF}}, 0};
      tbl[5] = '{105, {13{8'h96}}, 105};
      tbl[6] = '{1, {13{8'h81}}, 1};

      model_clear();
      repeat (3) @(posedge sysclk);
      #1;
      check_regs("reset", mreg);
      chk("reset cfg_valid", {31'h0, cfg_valid}, 32'h0);
      chk("reset frame_err", {31'h0, frame_err}, 32'h0);
      chk("reset bit_cnt", {25'h0, bit_cnt}, 32'h0);
      @(negedge sysclk);
      rst = 1'b1;
      repeat (3) @(negedge sysclk);

      // Table-driven frames: good, short, good again, saturating, empty, long, single
      for (int t = 0; t < 7; t++) begin
         shift_frame(tbl[t].data, tbl[t].nbits);
         chk($sformatf("tbl%0d bit_cnt", t), {25'h0, bit_cnt}, tbl[t].exp_cnt);
         capture($sformatf("tbl%0d", t), 1'b0, 1'b0);
      end

      // 104th sck rise coincides with scapt rise
      d = {13{8'h69}};
      shift_frame(d, 103);
      capture("same_cycle", 1'b1, d[0]);

      // Board reset mid-frame discards the partial frame
      shift_frame({13{8'hF0}}, 50);
      @(negedge sysclk);
      rst = 1'b0;
      model_clear();
      repeat (3) @(negedge sysclk);
      chk("rst bit_cnt", {25'h0, bit_cnt}, 32'h0);
      check_regs("rst", mreg);
      rst = 1'b1;
      repeat (3) @(negedge sysclk);
      shift_frame({13{8'hA5}}, 104);
      capture("after_rst", 1'b0, 1'b0);

      // Configuration reset request; sck pulses while it is held are ignored
      shift_frame({13{8'h33}}, 10);
      capture("bad_before_creset", 1'b0, 1'b0);
      @(negedge sysclk);
      creset = 1'b1;
      repeat (6) @(negedge sysclk);
      for (int p = 0; p < 3; p++) begin
         sck = 1'b1;
         repeat (4) @(negedge sysclk);
         sck = 1'b0;
         repeat (4) @(negedge sysclk);
      end
      repeat (6) @(negedge sysclk);
      model_clear();
      chk("creset bit_cnt", {25'h0, bit_cnt}, 32'h0);
      chk("creset frame_err", {31'h0, frame_err}, 32'h0);
      check_regs("creset", mreg);
      creset = 1'b0;
      repeat (5) @(negedge sysclk);
      chk("creset released bit_cnt", {25'h0, bit_cnt}, 32'h0);

      // Randomised frames against the model
      for (int f = 0; f < 10; f++) begin
         n   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 130) : 104;
         sim = (n > 0) && ($urandom_range(0, 1) == 1);
         for (int i = 0; i < (sim ? n - 1 : n); i++) shift_bit(1'($urandom_range(0, 1)));
         chk($sformatf("rnd%0d bit_cnt", f), {25'h0, bit_cnt}, exp_cnt());
         capture($sformatf("rnd%0d", f), sim, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
